rule110_host_driver: RTL and testbench
======================================

# rule110_host_driver

Host-side initiator for the rule110 cellular-automaton pin interface. It accepts commands from an on-board controller and drives the automaton's pins:
- LOAD streams cell bytes into the automaton.
- RUN advances it a counted number of generations.
- DUMP reads every block back out over a valid/ready stream.

It sits between a microcontroller-facing command bus and the automaton's data, control and address pins.

## Interface
Parameters:
- NUM_CELLS, 128, cells in the target automaton; multiple of 8.
- NUM_BLOCKS, NUM_CELLS/8, derived.
- USABLE_BLOCKS, NUM_BLOCKS-1, derived; the target maps the all-ones block address to 0, so the top block is unreachable.
- SETTLE, 1, cycles between driving ca_addr and sampling ca_data_out (1..3).
- GEN_BITS, 16, width of the RUN generation count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=NOP, 1=LOAD, 2=RUN, 3=DUMP.
- cmd_arg  in  GEN_BITS  generation count for RUN; ignored otherwise.
- load_data  in  8  cell byte; bit 0 is the lowest cell of the block.
- load_valid / load_ready  in / out  1  byte handshake.
- dump_data  out  8  block contents.
- dump_valid / dump_ready  out / in  1  block handshake.
- dump_last  out  1  high with the final dump byte.
- busy  out  1  high in any state other than IDLE.
- ca_data_in  out  8  drives the automaton data inputs.
- ca_we_n  out  1  write enable, active low.
- ca_halt_n  out  1  run enable, active low halt.
- ca_addr  out  6  block address.
- ca_data_out  in  8  automaton output view.

## Operation
- FSM states: IDLE, LOAD, RUN, DUMP_ADDR, DUMP_WAIT, DUMP_OUT. Encoding lives in the package.
- IDLE
  - Pin state: ca_we_n=1, ca_halt_n=0, ca_addr holds its last value.
  - A command is accepted on cmd_valid && cmd_ready.
  - NOP: stays in IDLE.
  - RUN with arg 0: completes with no pin activity.
- LOAD
  - load_ready=1; block index k starts at 0.
  - Each accepted byte registers ca_data_in=load_data, ca_addr=k, ca_we_n=0 for exactly one cycle; otherwise ca_we_n=1.
  - ca_halt_n stays 0 throughout.
  - After byte USABLE_BLOCKS-1 is accepted, go to IDLE; that final write pulse appears in IDLE's first cycle.
- RUN
  - A down-counter is loaded with cmd_arg.
  - ca_halt_n=1 for exactly cmd_arg consecutive cycles, then 0, then IDLE.
  - Each high cycle advances the target one generation.
- DUMP, per block k = 0..USABLE_BLOCKS-1:
  - DUMP_ADDR: drive ca_addr=k.
  - DUMP_WAIT: wait SETTLE cycles.
  - DUMP_OUT: capture ca_data_out into dump_data and assert dump_valid.
  - dump_data and dump_valid are held stable until dump_ready.
  - dump_last=1 on k=USABLE_BLOCKS-1.
  - After the last handshake, go to IDLE.
  - The captured value is the target's output view, i.e. the next generation of the halted state.
- Reset mid-operation: return to IDLE within the reset cycle. In-flight load/dump bytes are dropped. The target itself is not reset.
- ca_addr[5:log2(NUM_BLOCKS)] is always 0. k never reaches NUM_BLOCKS-1.

## Timing
- Reset values: cmd_ready=0 during reset and 1 from the first cycle after; busy=0, load_ready=0, dump_valid=0, dump_last=0, dump_data=0, ca_data_in=0, ca_we_n=1, ca_halt_n=0, ca_addr=0.
- All ca_* and dump_* outputs are registered. cmd_ready, load_ready and busy decode from the state register.
- LOAD throughput is one byte per cycle with load_valid held high, so a full load takes USABLE_BLOCKS cycles.
- RUN latency: accept edge to return to IDLE is cmd_arg+1 cycles.
- DUMP: first dump_valid appears SETTLE+2 cycles after the accept edge. Each byte takes SETTLE+2 cycles with dump_ready held high.
- Backpressure: dump_ready low freezes the address and data; no re-sample occurs.
- cmd_valid during busy: not accepted and has no effect.

## Structure
- Package rule110_host_pkg holds:
  - op encodings OP_NOP/OP_LOAD/OP_RUN/OP_DUMP;
  - the state enum;
  - CELLS_PER_BLOCK=8 and MAX_ADDRESS_BITS=6.
- Single module with no sub-module.
- Benches instantiate tt_um_rejunity_rule110 as the target model.

## Test plan
- Reset, then LOAD 15 bytes 0x00 except byte 0=0x02, then DUMP → dump bytes equal the target's next generation (byte0=0x03, others 0x00); dump_last on byte 14.
- LOAD 0x55 ×15 with load_valid gapped every other cycle → exactly 15 ca_we_n pulses; ca_addr 0..14; ca_halt_n never 1.
- RUN arg=5 → ca_halt_n high exactly 5 cycles; busy falls on cycle 6. RUN arg=0 → no ca_halt_n pulse.
- DUMP with dump_ready low for 10 cycles per byte → dump_data stable while valid; 15 bytes total, none duplicated.
- Assert reset during LOAD byte 7 → outputs at reset values next cycle; cmd_ready=1 the following cycle.
- cmd_valid with op=RUN while DUMP is in progress → ignored; dump completes unchanged.

Source files
------------

// File: rtl/rule110_host_pkg.sv
// Shared encodings for the rule110 host driver: command opcodes, FSM states
// and the fixed geometry of the automaton's pin interface.
package rule110_host_pkg;

  localparam int CELLS_PER_BLOCK  = 8;
  localparam int MAX_ADDRESS_BITS = 6;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_RUN  = 2'd2;
  localparam logic [1:0] OP_DUMP = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RUN       = 3'd2,
    ST_DUMP_ADDR = 3'd3,
    ST_DUMP_WAIT = 3'd4,
    ST_DUMP_OUT  = 3'd5
  } state_t;

endpackage

// File: rtl/rule110_host_driver.sv
// Host-side initiator for the rule110 automaton pins: streams cell bytes in,
// clocks a counted number of generations, and reads every usable block back.
module rule110_host_driver
  import rule110_host_pkg::*;
#(
  parameter int NUM_CELLS     = 128,
  parameter int NUM_BLOCKS    = NUM_CELLS / CELLS_PER_BLOCK,
  parameter int USABLE_BLOCKS = NUM_BLOCKS - 1,
  parameter int SETTLE        = 1,
  parameter int GEN_BITS      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [GEN_BITS-1:0]         cmd_arg,
  input  logic [7:0]                  load_data,
  input  logic                        load_valid,
  output logic                        load_ready,
  output logic [7:0]                  dump_data,
  output logic                        dump_valid,
  input  logic                        dump_ready,
  output logic                        dump_last,
  output logic                        busy,
  output logic [7:0]                  ca_data_in,
  output logic                        ca_we_n,
  output logic                        ca_halt_n,
  output logic [MAX_ADDRESS_BITS-1:0] ca_addr,
  input  logic [7:0]                  ca_data_out
);

  localparam int BLK_W = $clog2(NUM_BLOCKS);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(USABLE_BLOCKS - 1);
  localparam logic [1:0] SETTLE_INIT = 2'(SETTLE - 1);

  state_t              state_r;
  logic [BLK_W-1:0]    blk_r;
  logic [GEN_BITS-1:0] gen_cnt_r;
  logic [1:0]          settle_cnt_r;

  assign cmd_ready  = (state_r == ST_IDLE) && !reset;
  assign busy       = (state_r != ST_IDLE);
  assign load_ready = (state_r == ST_LOAD);

  // Command sequencer; all pin and stream outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      blk_r        <= '0;
      gen_cnt_r    <= '0;
      settle_cnt_r <= 2'd0;
      dump_data    <= 8'h00;
      dump_valid   <= 1'b0;
      dump_last    <= 1'b0;
      ca_data_in   <= 8'h00;
      ca_we_n      <= 1'b1;
      ca_halt_n    <= 1'b0;
      ca_addr      <= '0;
    end else begin
      ca_we_n <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          ca_halt_n <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            case (cmd_op)
              OP_LOAD: begin
                state_r <= ST_LOAD;
                blk_r   <= '0;
              end
              OP_RUN: begin
                if (cmd_arg != '0) begin
                  state_r   <= ST_RUN;
                  gen_cnt_r <= cmd_arg;
                  ca_halt_n <= 1'b1;
                end else begin
                  state_r <= ST_IDLE;
                end
              end
              OP_DUMP: begin
                state_r <= ST_DUMP_ADDR;
                blk_r   <= '0;
              end
              default: state_r <= ST_IDLE;
            endcase
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            ca_data_in <= load_data;
            ca_addr    <= MAX_ADDRESS_BITS'(blk_r);
            ca_we_n    <= 1'b0;
            if (blk_r == LAST_BLK) begin
              state_r <= ST_IDLE;
            end else begin
              blk_r <= blk_r + 1'b1;
            end
          end
        end
        // Halt stays high while the counter is non-zero, then one low cycle.
        ST_RUN: begin
          if (gen_cnt_r != '0) begin
            gen_cnt_r <= gen_cnt_r - 1'b1;
            ca_halt_n <= (gen_cnt_r != GEN_BITS'(1));
          end else begin
            ca_halt_n <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        ST_DUMP_ADDR: begin
          ca_addr      <= MAX_ADDRESS_BITS'(blk_r);
          settle_cnt_r <= SETTLE_INIT;
          state_r      <= ST_DUMP_WAIT;
        end
        ST_DUMP_WAIT: begin
          if (settle_cnt_r == 2'd0) begin
            state_r <= ST_DUMP_OUT;
          end else begin
            settle_cnt_r <= settle_cnt_r - 2'd1;
          end
        end
        // The handshake edge also drives the next address, saving a cycle per block.
        ST_DUMP_OUT: begin
          if (!dump_valid) begin
            dump_data  <= ca_data_out;
            dump_valid <= 1'b1;
            dump_last  <= (blk_r == LAST_BLK);
          end else if (dump_ready) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            if (blk_r == LAST_BLK) begin
              state_r <= ST_IDLE;
            end else begin
              blk_r        <= blk_r + 1'b1;
              ca_addr      <= MAX_ADDRESS_BITS'(blk_r + 1'b1);
              settle_cnt_r <= SETTLE_INIT;
              state_r      <= ST_DUMP_WAIT;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rule110_host_driver.sv
// Self-checking bench for rule110_host_driver with a behavioural rule110 target
// on the pins and an independent array-based reference of the cell state.
module tb_rule110_host_driver;
  import rule110_host_pkg::*;

  localparam int NUM_CELLS = 128;
  localparam int USABLE    = 15;
  localparam int SETTLE    = 1;

  typedef logic [7:0] blk_arr_t [USABLE];
  typedef int cells_t [NUM_CELLS];
  typedef struct { logic [7:0] b0; logic [7:0] exp0; logic [7:0] exp1; } pat_t;
  typedef struct { int arg; int exp_halt; int exp_busy; } run_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic [7:0]  load_data;
  logic        load_valid, load_ready;
  logic [7:0]  dump_data;
  logic        dump_valid, dump_ready, dump_last, busy;
  logic [7:0]  ca_data_in;
  logic        ca_we_n, ca_halt_n;
  logic [5:0]  ca_addr;
  logic [7:0]  ca_data_out;

  int n_chk = 0;
  int n_err = 0;
  int halt_hi_cnt = 0;
  cells_t ref_cells;

  rule110_host_driver dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .load_data(load_data),
    .load_valid(load_valid), .load_ready(load_ready), .dump_data(dump_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_last(dump_last),
    .busy(busy), .ca_data_in(ca_data_in), .ca_we_n(ca_we_n),
    .ca_halt_n(ca_halt_n), .ca_addr(ca_addr), .ca_data_out(ca_data_out)
  );

  always #5 clk = ~clk;

  // Target automaton: rule 110 as (c ^ r) | (c & ~l), left neighbour is cell i-1.
  logic [NUM_CELLS-1:0] tgt_cells = '0;
  logic [NUM_CELLS-1:0] tgt_next;
  logic [3:0]           tgt_blk;
  always_comb begin
    tgt_next    = (tgt_cells ^ (tgt_cells >> 1)) | (tgt_cells & ~(tgt_cells << 1));
    tgt_blk     = (ca_addr[3:0] == 4'hF) ? 4'h0 : ca_addr[3:0];
    ca_data_out = tgt_next[tgt_blk*8 +: 8];
  end
  always @(posedge clk) begin
    if (!ca_we_n) tgt_cells[tgt_blk*8 +: 8] <= ca_data_in;
    else if (ca_halt_n) tgt_cells <= tgt_next;
  end

  always @(negedge clk) if (ca_halt_n === 1'b1) halt_hi_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: rule number 110 looked up by neighbourhood index.
  function automatic cells_t gen_next(cells_t c);
    cells_t n;
    int l, r;
    for (int i = 0; i < NUM_CELLS; i++) begin
      l = (i == 0) ? 0 : c[i-1];
      r = (i == NUM_CELLS - 1) ? 0 : c[i+1];
      n[i] = (110 >> (l * 4 + c[i] * 2 + r)) & 1;
    end
    return n;
  endfunction

  function automatic logic [7:0] exp_byte(int k);
    cells_t n;
    logic [7:0] b;
    n = gen_next(ref_cells);
    for (int j = 0; j < 8; j++) b[j] = (n[k*8+j] != 0);
    return b;
  endfunction

  function automatic void ref_load(blk_arr_t d, int nblk);
    for (int b = 0; b < nblk; b++)
      for (int j = 0; j < 8; j++) ref_cells[b*8+j] = d[b][j] ? 1 : 0;
  endfunction

  function automatic void ref_step(int n);
    for (int i = 0; i < n; i++) ref_cells = gen_next(ref_cells);
  endfunction

  task automatic issue_cmd(input logic [1:0] op, input logic [15:0] arg);
    int w = 0;
    while (!cmd_ready && w < 100) begin tick(); w++; end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    tick();
    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = 16'd0;
  endtask

  task automatic do_load(input blk_arr_t d, input bit gapped);
    int sent = 0, pulses = 0, cyc = 0, extra = 0, h0;
    bit pins_ok = 1'b1;
    bit acc;
    h0 = halt_hi_cnt;
    issue_cmd(OP_LOAD, 16'd0);
    while (sent < USABLE && cyc < 200) begin
      load_valid = gapped ? (cyc % 2 == 1) : 1'b1;
      load_data  = d[sent];
      acc = load_valid && load_ready;
      tick();
      cyc++;
      if (acc) sent++;
      if (!ca_we_n) begin
        if (pulses >= USABLE || ca_addr != 6'(pulses) || ca_data_in != d[pulses]) pins_ok = 1'b0;
        pulses++;
      end
    end
    load_valid = 1'b0;
    chk("load_final_pulse_in_idle", {busy, ca_we_n}, 2'b00);
    if (!gapped) chk("load_cycles", cyc, USABLE);
    for (int i = 0; i < 3; i++) begin tick(); if (!ca_we_n) extra++; end
    chk("load_we_pulses", pulses + extra, USABLE);
    chk("load_addr_data", pins_ok, 1'b1);
    chk("load_halt_quiet", halt_hi_cnt - h0, 0);
    ref_load(d, USABLE);
  endtask

  task automatic do_run(input int arg, output int halt_cyc, output int busy_cyc, output int rises);
    int h0;
    logic prev = 1'b0;
    busy_cyc = 0; rises = 0;
    h0 = halt_hi_cnt;
    issue_cmd(OP_RUN, 16'(arg));
    for (int i = 0; i < arg + 6; i++) begin
      if (busy) busy_cyc++;
      if (ca_halt_n && !prev) rises++;
      prev = ca_halt_n;
      tick();
    end
    halt_cyc = halt_hi_cnt - h0;
    ref_step(arg);
  endtask

  task automatic do_dump(input int stall, input bit rand_stall, input bit inject,
                         input bit check_lat, output blk_arr_t got);
    int k = 0, t = 0, prev_t = 0, s, extra = 0, h0;
    bit stable_ok = 1'b1, period_ok = 1'b1;
    logic [7:0] held;
    h0 = halt_hi_cnt;
    issue_cmd(OP_DUMP, 16'd0);
    if (inject) begin cmd_valid = 1'b1; cmd_op = OP_RUN; cmd_arg = 16'd7; end
    while (k < USABLE && t < 3000) begin
      if (dump_valid) begin
        if (k == 0 && check_lat) chk("dump_first_latency", t, SETTLE + 2);
        if (k > 0 && stall == 0 && !rand_stall && (t - prev_t) != SETTLE + 2) period_ok = 1'b0;
        prev_t = t;
        held = dump_data;
        s = rand_stall ? $urandom_range(0, 3) : stall;
        for (int i = 0; i < s; i++) begin
          tick(); t++;
          if (!dump_valid || dump_data != held) stable_ok = 1'b0;
        end
        got[k] = dump_data;
        chk($sformatf("dump_byte%0d", k), dump_data, exp_byte(k));
        chk($sformatf("dump_last%0d", k), dump_last, (k == USABLE - 1));
        if (k == USABLE - 1) cmd_valid = 1'b0;
        dump_ready = 1'b1;
        tick(); t++;
        dump_ready = 1'b0;
        k++;
      end else begin
        tick(); t++;
      end
    end
    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = 16'd0;
    chk("dump_count", k, USABLE);
    chk("dump_stable", stable_ok, 1'b1);
    if (stall == 0 && !rand_stall) chk("dump_period", period_ok, 1'b1);
    for (int i = 0; i < 5; i++) begin if (dump_valid) extra++; tick(); end
    chk("dump_no_extra", extra, 0);
    chk("dump_idle", busy, 1'b0);
    chk("dump_halt_quiet", halt_hi_cnt - h0, 0);
  endtask

  initial begin
    pat_t pats [4];
    run_t runs [4];
    blk_arr_t d, got;
    int hc, bc, rc;

    pats[0] = '{8'h02, 8'h03, 8'h00};
    pats[1] = '{8'h80, 8'hC0, 8'h00};
    pats[2] = '{8'h01, 8'h01, 8'h00};
    pats[3] = '{8'hFF, 8'h81, 8'h00};
    runs[0] = '{5, 5, 6};
    runs[1] = '{0, 0, 0};
    runs[2] = '{1, 1, 2};
    runs[3] = '{3, 3, 4};
    for (int i = 0; i < NUM_CELLS; i++) ref_cells[i] = 0;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = 16'd0;
    load_data = 8'h00; load_valid = 1'b0; dump_ready = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready_low", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_load_ready", load_ready, 1'b0);
    chk("rst_dump", {dump_valid, dump_last, dump_data}, 10'd0);
    chk("rst_ca_pins", {ca_we_n, ca_halt_n, ca_addr, ca_data_in}, {1'b1, 1'b0, 6'd0, 8'h00});
    reset = 1'b0;
    #1;
    chk("rst_cmd_ready_after", cmd_ready, 1'b1);

    // Single-cell and saturated seeds in block 0.
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < USABLE; b++) d[b] = 8'h00;
      d[0] = pats[p].b0;
      do_load(d, 1'b0);
      do_dump(0, 1'b0, 1'b0, (p == 0), got);
      chk($sformatf("pat%0d_blk0", p), got[0], pats[p].exp0);
      chk($sformatf("pat%0d_blk1", p), got[1], pats[p].exp1);
    end

    for (int b = 0; b < USABLE; b++) d[b] = 8'h55;
    do_load(d, 1'b1);

    for (int r = 0; r < 4; r++) begin
      do_run(runs[r].arg, hc, bc, rc);
      chk($sformatf("run%0d_halt_cycles", runs[r].arg), hc, runs[r].exp_halt);
      chk($sformatf("run%0d_busy_cycles", runs[r].arg), bc, runs[r].exp_busy);
      chk($sformatf("run%0d_halt_rises", runs[r].arg), rc, (runs[r].arg != 0) ? 1 : 0);
    end

    do_dump(10, 1'b0, 1'b0, 1'b0, got);
    do_dump(0, 1'b0, 1'b1, 1'b0, got);

    // Reset arrives while byte 7 of a load is being offered.
    for (int b = 0; b < USABLE; b++) d[b] = 8'($urandom);
    issue_cmd(OP_LOAD, 16'd0);
    load_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin load_data = d[i]; tick(); end
    load_data = d[7];
    reset = 1'b1;
    #1;
    chk("midload_cmd_ready_in_reset", cmd_ready, 1'b0);
    tick();
    reset = 1'b0; load_valid = 1'b0;
    #1;
    chk("midload_rst_state", {busy, load_ready, dump_valid, dump_data}, 11'd0);
    chk("midload_rst_pins", {ca_we_n, ca_halt_n, ca_addr, ca_data_in}, {1'b1, 1'b0, 6'd0, 8'h00});
    chk("midload_cmd_ready_after", cmd_ready, 1'b1);
    ref_load(d, 7);
    tick();
    chk("midload_no_more_writes", ca_we_n, 1'b1);
    do_dump(0, 1'b0, 1'b0, 1'b0, got);

    for (int it = 0; it < 3; it++) begin
      for (int b = 0; b < USABLE; b++) d[b] = 8'($urandom);
      do_load(d, (it == 1));
      do_run($urandom_range(1, 6), hc, bc, rc);
      chk("rand_run_busy_vs_halt", bc, hc + 1);
      do_dump(0, 1'b1, (it == 2), 1'b0, got);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
